// File: rtl/sort_pkg.sv
// Shared types and sizing constants for the 3-value sorter front end.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STROBE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/sort_feeder.sv
// Packs three stream bytes into stable sorter operands, strobes SORT and
// holds the triplet through a settle window until the consumer acknowledges.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_FILL    | accepting bytes into A/B/C, in_ready high
// ST_STROBE  | one-cycle SORT pulse, operands frozen
// ST_SETTLE  | waiting for the sorter network to settle
// ST_HOLD    | trip_valid high until trip_ack
module sort_feeder
  import sort_pkg::*;
#(
  parameter int               WIDTH  = WIDTH_DEF,
  parameter logic [WIDTH-1:0] PAD    = '0,
  parameter int               SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             SORT,
  output logic [1:0]       n_valid,
  output logic             trip_valid,
  input  logic             trip_ack
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_c;
  logic               r_sort;
  logic [1:0]         r_nvalid;
  logic               w_accept;
  logic               w_done;

  // No path from in_valid; rst_n gating keeps the stream stalled during reset.
  assign in_ready = (r_state == ST_FILL) && rst_n;
  assign w_accept = in_valid && (r_state == ST_FILL);
  assign w_done   = in_last || (r_idx == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FILL;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_sort   <= 1'b0;
      r_nvalid <= 2'd0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            case (r_idx)
              2'd0:    r_a <= in_data;
              2'd1:    r_b <= in_data;
              default: r_c <= in_data;
            endcase
            r_idx <= r_idx + 2'd1;
            if (w_done) begin
              r_state  <= ST_STROBE;
              r_sort   <= 1'b1;
              r_nvalid <= r_idx + 2'd1;
              // Short group: fill the untouched upper slots in the same edge.
              if (r_idx == 2'd0) begin
                r_b <= PAD;
                r_c <= PAD;
              end else if (r_idx == 2'd1) begin
                r_c <= PAD;
              end
            end
          end
        end
        ST_STROBE: begin
          r_sort  <= 1'b0;
          r_cnt   <= SETTLE_LOAD;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) r_state <= ST_HOLD;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_HOLD: begin
          if (trip_ack) begin
            r_state <= ST_FILL;
            r_idx   <= 2'd0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign C          = r_c;
  assign SORT       = r_sort;
  assign n_valid    = r_nvalid;
  assign trip_valid = (r_state == ST_HOLD);

endmodule

// File: tb/tb_sort_feeder.sv
// Scoreboard bench for sort_feeder: expected triplets are queued as groups are
// driven and compared when trip_valid rises.
module tb_sort_feeder;

  localparam int SETTLE = 2;
  localparam logic [7:0] PAD = 8'h00;

  typedef struct {
    logic [7:0] a, b, c;
    logic [1:0] n;
  } trip_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] A, B, C;
  logic       SORT;
  logic [1:0] n_valid;
  logic       trip_valid;
  logic       trip_ack;

  int    n_checks = 0;
  int    n_errors = 0;
  trip_t sb[$];

  sort_feeder #(.WIDTH(8), .PAD(PAD), .SETTLE(SETTLE)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .C          (C),
    .SORT       (SORT),
    .n_valid    (n_valid),
    .trip_valid (trip_valid),
    .trip_ack   (trip_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    bit done = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_group(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input bit last_on_third);
    logic [7:0] b[3];
    trip_t e;
    b = '{b0, b1, b2};
    e.a = b0;
    e.b = (n > 1) ? b1 : PAD;
    e.c = (n > 2) ? b2 : PAD;
    e.n = 2'(n);
    sb.push_back(e);
    for (int i = 0; i < n; i++)
      send_beat(b[i], (i == n - 1) && (n < 3 || last_on_third));
  endtask

  // Called at e0+1: checks strobe shape, latency and the scoreboard entry.
  task automatic wait_trip(input bit ack_pulse);
    int    cnt = 0;
    bit    found = 0;
    trip_t e;
    check("sort_hi", {31'd0, SORT}, 32'd1);
    check("ready_lo_strobe", {31'd0, in_ready}, 32'd0);
    if (ack_pulse) trip_ack = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (k == 0) check("sort_lo", {31'd0, SORT}, 32'd0);
      if (k == 1) trip_ack = 1'b0;
      if (trip_valid) found = 1;
    end
    trip_ack = 1'b0;
    if (!found) check("trip_timeout", 32'd0, 32'd1);
    else        check("trip_latency", cnt, SETTLE + 1);
    check("ready_lo_hold", {31'd0, in_ready}, 32'd0);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow got=empty exp=entry");
    end else begin
      n_checks--;
      e = sb.pop_front();
      check("op_a", A, e.a);
      check("op_b", B, e.b);
      check("op_c", C, e.c);
      check("n_valid", n_valid, e.n);
    end
  endtask

  task automatic do_ack();
    trip_ack = 1'b1;
    @(posedge clk);
    #1;
    trip_ack = 1'b0;
    check("ack_tv_lo", {31'd0, trip_valid}, 32'd0);
    check("ack_ready_hi", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit stable;
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    trip_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_sort", {31'd0, SORT}, 32'd0);
    check("rst_tv", {31'd0, trip_valid}, 32'd0);
    check("rst_abc", {8'd0, A, B, C}, 32'd0);
    check("rst_nv", n_valid, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, in_ready}, 32'd1);

    // Full group, then short groups
    send_group(8'h30, 8'h10, 8'h20, 3, 0);
    wait_trip(0);
    do_ack();
    send_group(8'h05, 8'h07, 8'h00, 2, 0);
    wait_trip(0);
    do_ack();
    send_group(8'hAA, 8'h00, 8'h00, 1, 0);
    wait_trip(1);
    do_ack();

    // Long hold with in_valid pushing
    send_group(8'h11, 8'h22, 8'h33, 3, 1);
    wait_trip(0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    stable   = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (A !== 8'h11 || B !== 8'h22 || C !== 8'h33 || !trip_valid || in_ready) stable = 0;
    end
    in_valid = 1'b0;
    check("hold_stable", {31'd0, stable}, 32'd1);
    do_ack();
    send_beat(8'h44, 1'b0);
    check("next_in_a", A, 8'h44);

    // Ack pulse during FILL must be ignored
    trip_ack = 1'b1;
    @(posedge clk);
    #1;
    trip_ack = 1'b0;
    check("fill_ack_ready", {31'd0, in_ready}, 32'd1);
    check("fill_ack_tv", {31'd0, trip_valid}, 32'd0);
    check("fill_ack_a", A, 8'h44);
    sb.push_back('{a: 8'h44, b: 8'h55, c: PAD, n: 2'd2});
    send_beat(8'h55, 1'b1);
    wait_trip(0);
    do_ack();

    // Reset during SETTLE
    send_group(8'h61, 8'h62, 8'h63, 3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sort", {31'd0, SORT}, 32'd0);
    check("mid_rst_tv", {31'd0, trip_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_abc", {8'd0, A, B, C}, 32'd0);
    check("mid_rst_nv", n_valid, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    send_group(8'h01, 8'h02, 8'h03, 3, 1);
    wait_trip(0);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sort_feeder.md
# sort_feeder

Upstream loader for the 3-value sorter. Accepts a byte stream over a valid/ready handshake, packs three consecutive bytes into stable operand registers A/B/C, and issues a one-cycle registered SORT strobe. It then holds the operands for a settle window and for as long as the downstream consumer needs. Short groups are padded so the sorter always sees three operands.

## Interface
- WIDTH, 8, operand width in bits
- PAD, {WIDTH{1'b0}}, fill value for operand slots left unfilled by an early in_last
- SETTLE, 2, cycles the triplet is held after SORT before trip_valid; legal range 1..15

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  WIDTH  input byte
- in_valid  in  1  in_data valid
- in_last  in  1  final byte of a group; qualified by in_valid
- in_ready  out  1  feeder can accept a byte
- A, B, C  out  WIDTH each  sorter operands; registered
- SORT  out  1  registered one-cycle sort strobe
- n_valid  out  2  number of real (non-PAD) operands in the current triplet, 1..3
- trip_valid  out  1  triplet settled; sorter outputs valid
- trip_ack  in  1  consumer has taken the sorted result

## Operation
- Reset: A=B=C=0, SORT=0, n_valid=0, trip_valid=0, slot index=0, state=FILL. in_ready is forced 0 while rst_n is low.
- States: FILL, STROBE, SETTLE, HOLD.
- FILL: in_ready=1. Each beat with in_valid&in_ready writes in_data to the slot selected by the index (0→A, 1→B, 2→C), then increments the index.
  - The third accepted beat, or any accepted beat with in_last=1, moves to STROBE.
  - When the group ends early, slots above the last written one load PAD in the same edge. n_valid is set to the count of accepted beats.
  - in_last on the third beat is equivalent to a normal third beat.
- STROBE: in_ready=0 and SORT=1 for exactly one cycle. Moves to SETTLE and loads the settle counter with SETTLE-1.
- SETTLE: the counter decrements each cycle. When it reaches 0, the state moves to HOLD.
- HOLD: trip_valid=1. On trip_ack=1 the state moves to FILL, the index clears, and n_valid holds until the next triplet.
- A/B/C change only on accepted FILL beats. They are stable from the STROBE cycle until HOLD exits.
- trip_ack is ignored outside HOLD. in_valid is ignored outside FILL; no byte is lost because in_ready=0.
- SORT is driven straight from a flop with no combinational logic after it, so the event-triggered sorter never sees a glitch.
- Reset mid-operation drops SORT and trip_valid immediately and discards the partial group.

## Timing
- The final byte of a group is accepted at edge e0. From there:
  - SORT is high in cycle e0..e1.
  - The state is SETTLE for e1..e(1+SETTLE).
  - trip_valid rises at e(1+SETTLE). With the default SETTLE=2, that is 3 edges after e0.
- trip_ack sampled high at edge ek: trip_valid falls and in_ready rises at ek. The earliest next accept is edge ek+1.
- Minimum triplet period at full throughput with trip_ack tied high: 3 fill + 1 strobe + SETTLE + 1 hold cycles.
- in_ready is a pure decode of state, with no combinational path from in_valid.

## Structure
- Shared package sort_pkg holds the state enum (FILL, STROBE, SETTLE, HOLD), the default WIDTH, and the settle counter width.
- Single module, no sub-module. The settle counter is inline, 4 bits.

## Test plan
- Reset release, then bytes 8'h30, 8'h10, 8'h20 back-to-back → A=30, B=10, C=20, n_valid=3. SORT is high one cycle after the third accept, trip_valid rises 3 edges after it, and in_ready=0 until trip_ack.
- 8'h05 then 8'h07 with in_last=1 → A=05, B=07, C=00 (PAD), n_valid=2, and the strobe follows immediately.
- Single byte 8'hAA with in_last=1 → n_valid=1, B=C=00.
- Hold trip_ack low for 10 cycles with in_valid high throughout → A/B/C unchanged, no beat accepted, trip_valid stays 1. Ack then resumes FILL and the next byte lands in A.
- Assert rst_n=0 during SETTLE → all outputs go to reset values asynchronously, and the next group after release starts at slot A.
- Pulse trip_ack during FILL and SETTLE → no effect on state or outputs.
